// File: rtl/byte_strip_n.sv
// byte_strip_n: round-robin striper of one word stream across LANES output lanes,
// with group staging, backpressure and partial-group flush. Optional parity via BYTE_STRIP_PARITY_EN.

module byte_strip_lane #(
  parameter int DATA_W = 32
) (
  input  logic              clk_f,
  input  logic              reset_L,
  input  logic              wr,       // stage the incoming word without loading the bank
  input  logic              take_in,  // incoming word belongs to this lane on a bank load
  input  logic              load,
  input  logic              rel,
  input  logic [DATA_W-1:0] data_in,
  output logic              mask_q,
  output logic [DATA_W-1:0] lane_q,
  output logic              vld_q
`ifdef BYTE_STRIP_PARITY_EN
  ,
  output logic              parity_q
`endif
);

  logic [DATA_W-1:0] stage_q;
  logic [DATA_W-1:0] bank_nxt;

  // Unfilled lanes of a flushed group carry zero data.
  always_comb begin
    bank_nxt = '0;
    if (take_in)     bank_nxt = data_in;
    else if (mask_q) bank_nxt = stage_q;
  end

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      stage_q <= '0;
      mask_q  <= 1'b0;
      lane_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      if (wr) begin
        stage_q <= data_in;
        mask_q  <= 1'b1;
      end
      if (load) begin
        lane_q <= bank_nxt;
        vld_q  <= take_in | mask_q;
        mask_q <= 1'b0;
      end else if (rel) begin
        vld_q  <= 1'b0;
      end
    end
  end

`ifdef BYTE_STRIP_PARITY_EN
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L)  parity_q <= 1'b0;
    else if (load) parity_q <= ^bank_nxt;
  end
`endif

endmodule

module byte_strip_n #(
  parameter int DATA_W = 32,
  parameter int LANES  = 2,
  parameter int PTR_W  = $clog2(LANES)
) (
  input  logic                    clk_f,
  input  logic                    reset_L,
  input  logic                    valid_in,
  input  logic [DATA_W-1:0]       data_in,
  output logic                    in_ready,
  input  logic                    flush_in,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] lanes_out,
  output logic [LANES-1:0]        valid_out
`ifdef BYTE_STRIP_PARITY_EN
  ,
  output logic [LANES-1:0]        parity_out
`endif
);

  logic [PTR_W-1:0]              ptr;
  logic [LANES-1:0]              stage_mask;
  logic [LANES-1:0]              vld_w;
  logic [LANES-1:0][DATA_W-1:0]  lane_q;
  logic bank_free, last, accept, complete, flush_take, load, release_bank;

  assign bank_free    = (vld_w == '0) || out_ready;
  assign last         = (ptr == PTR_W'(LANES-1));
  assign in_ready     = !((last || flush_in) && !bank_free);
  assign accept       = valid_in && in_ready;
  assign complete     = accept && last;
  // An empty flush with no incoming word must not disturb the bank.
  assign flush_take   = flush_in && bank_free && ((stage_mask != '0) || accept);
  assign load         = complete || flush_take;
  assign release_bank = bank_free && !load;

  assign lanes_out = lane_q;
  assign valid_out = vld_w;

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L)    ptr <= '0;
    else if (load)   ptr <= '0;
    else if (accept) ptr <= ptr + PTR_W'(1);
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic sel;
    assign sel = (ptr == PTR_W'(k));

    byte_strip_lane #(.DATA_W(DATA_W)) u_lane (
      .clk_f    (clk_f),
      .reset_L  (reset_L),
      .wr       (accept && sel && !load),
      .take_in  (accept && sel),
      .load     (load),
      .rel      (release_bank),
      .data_in  (data_in),
      .mask_q   (stage_mask[k]),
      .lane_q   (lane_q[k]),
      .vld_q    (vld_w[k])
`ifdef BYTE_STRIP_PARITY_EN
      ,
      .parity_q (parity_out[k])
`endif
    );
  end

endmodule

// File: tb/tb_byte_strip_n.sv
// Bench for byte_strip_n: LANES=2 and LANES=4 instances checked against a queue-style
// group model with directed scenarios followed by random traffic.

module tb_byte_strip_n;

  logic clk_f = 1'b0;
  always #5 clk_f = ~clk_f;

  logic        reset_L;
  logic        v2, f2, or2, ir2;
  logic [31:0] d2;
  logic [63:0] lo2;
  logic [1:0]  vo2;
  logic        v4, f4, or4, ir4;
  logic [31:0] d4;
  logic [127:0] lo4;
  logic [3:0]  vo4;
`ifdef BYTE_STRIP_PARITY_EN
  logic [1:0]  p2;
  logic [3:0]  p4;
`endif

  byte_strip_n #(.DATA_W(32), .LANES(2)) dut2 (
    .clk_f(clk_f), .reset_L(reset_L), .valid_in(v2), .data_in(d2), .in_ready(ir2),
    .flush_in(f2), .out_ready(or2), .lanes_out(lo2), .valid_out(vo2)
`ifdef BYTE_STRIP_PARITY_EN
    , .parity_out(p2)
`endif
  );

  byte_strip_n #(.DATA_W(32), .LANES(4)) dut4 (
    .clk_f(clk_f), .reset_L(reset_L), .valid_in(v4), .data_in(d4), .in_ready(ir4),
    .flush_in(f4), .out_ready(or4), .lanes_out(lo4), .valid_out(vo4)
`ifdef BYTE_STRIP_PARITY_EN
    , .parity_out(p4)
`endif
  );

  // Model: list of words waiting for a group, plus the presented bank.
  logic [31:0] stg [2][8];
  int          cnt [2];
  logic [31:0] md  [2][8];
  logic [7:0]  mv  [2];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic int lanes_of(int i);
    return (i == 0) ? 2 : 4;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_rdy(int i, bit fl, bit ordy);
    bit free;
    free = (mv[i] == 8'd0) || ordy;
    return !(((cnt[i] == lanes_of(i) - 1) || fl) && !free);
  endfunction

  function automatic logic [127:0] exp_lanes(int i);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < lanes_of(i); k++) r[k*32 +: 32] = md[i][k];
    return r;
  endfunction

  function automatic logic [127:0] exp_par(int i);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < lanes_of(i); k++) r[k] = ^md[i][k];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      cnt[i] = 0;
      mv[i]  = 8'd0;
      for (int k = 0; k < 8; k++) begin
        md[i][k]  = 32'd0;
        stg[i][k] = 32'd0;
      end
    end
  endtask

  task automatic model_step(input int i, input bit v, input logic [31:0] d, input bit fl, input bit ordy);
    bit free, rdy;
    int L;
    L    = lanes_of(i);
    free = (mv[i] == 8'd0) || ordy;
    rdy  = exp_rdy(i, fl, ordy);
    if (v && rdy) begin
      stg[i][cnt[i]] = d;
      cnt[i]++;
    end
    if (cnt[i] == L || (fl && free && cnt[i] > 0)) begin
      for (int k = 0; k < 8; k++) md[i][k] = (k < cnt[i]) ? stg[i][k] : 32'd0;
      mv[i]  = 8'((1 << cnt[i]) - 1);
      cnt[i] = 0;
    end else if (free) begin
      mv[i] = 8'd0;
    end
  endtask

  // Called just after a rising edge with inputs already set for the coming edge.
  task automatic cyc();
    #1;
    chk("rdy2", {127'd0, ir2}, {127'd0, exp_rdy(0, f2, or2)});
    chk("rdy4", {127'd0, ir4}, {127'd0, exp_rdy(1, f4, or4)});
    model_step(0, v2, d2, f2, or2);
    model_step(1, v4, d4, f4, or4);
    @(posedge clk_f); #1;
    chk("vld2",   {126'd0, vo2}, {120'd0, mv[0]} & 128'h3);
    chk("lanes2", {64'd0, lo2},  exp_lanes(0));
    chk("vld4",   {124'd0, vo4}, {120'd0, mv[1]} & 128'hF);
    chk("lanes4", lo4,           exp_lanes(1));
`ifdef BYTE_STRIP_PARITY_EN
    chk("par2", {126'd0, p2}, exp_par(0));
    chk("par4", {124'd0, p4}, exp_par(1));
`endif
  endtask

  task automatic idle();
    v2 = 0; f2 = 0; d2 = '0;
    v4 = 0; f4 = 0; d4 = '0;
  endtask

  task automatic push4(input logic [31:0] w);
    v4 = 1; d4 = w; cyc(); v4 = 0;
  endtask

  initial begin
    idle(); or2 = 1; or4 = 1;
    reset_L = 1'b0;
    model_clear();
    #12;
    chk("rst_vld4",   {124'd0, vo4}, 128'd0);
    chk("rst_lanes4", lo4, 128'd0);
    chk("rst_vld2",   {126'd0, vo2}, 128'd0);
    reset_L = 1'b1;
    @(posedge clk_f); #1;

    // Two-lane group, one-cycle latency, single-cycle valid.
    v2 = 1; d2 = 32'hAAAA0001; cyc();
    d2 = 32'hBBBB0002; cyc();
    chk("t1_lanes", {64'd0, lo2}, {64'd0, 64'hBBBB0002_AAAA0001});
    chk("t1_vld",   {126'd0, vo2}, 128'h3);
    v2 = 0; cyc();
    chk("t1_rel", {126'd0, vo2}, 128'h0);

    // Gaps in valid_in do not skip lanes.
    for (int w = 1; w <= 3; w++) begin
      push4(w); cyc(); cyc();
      chk("t2_nov", {124'd0, vo4}, 128'h0);
    end
    push4(4);
    chk("t2_lanes", lo4, {32'd4, 32'd3, 32'd2, 32'd1});
    chk("t2_vld",   {124'd0, vo4}, 128'hF);
    cyc();
    chk("t2_once",  {124'd0, vo4}, 128'h0);

    // Backpressure: last word stalls until out_ready, then replaces with no gap.
    for (int w = 0; w < 4; w++) push4(32'h10 + w);
    or4 = 0;
    for (int w = 0; w < 3; w++) push4(32'h20 + w);
    v4 = 1; d4 = 32'h23;
    #1; chk("t3_stall", {127'd0, ir4}, 128'd0);
    cyc();
    chk("t3_hold", lo4, {32'h13, 32'h12, 32'h11, 32'h10});
    or4 = 1; cyc(); v4 = 0;
    chk("t3_new",  lo4, {32'h23, 32'h22, 32'h21, 32'h20});
    chk("t3_nogap", {124'd0, vo4}, 128'hF);
    cyc();

    // Flush of a two-word partial group, then the next word lands in lane 0.
    push4(32'h11); push4(32'h22);
    f4 = 1; cyc(); f4 = 0;
    chk("t4_lanes", lo4, {32'h0, 32'h0, 32'h22, 32'h11});
    chk("t4_vld",   {124'd0, vo4}, 128'h3);
    f4 = 1; cyc(); f4 = 0;
    chk("t4_empty", {124'd0, vo4}, 128'h0);
    for (int w = 0; w < 4; w++) push4(32'h33 + w);
    chk("t4_lane0", {96'd0, lo4[31:0]}, 128'h33);

    // Async reset mid-group with a held bank.
    or4 = 0;
    for (int w = 0; w < 4; w++) push4(32'h40 + w);
    push4(32'h50); push4(32'h51);
    reset_L = 1'b0;
    #1;
    chk("t5_vld",   {124'd0, vo4}, 128'h0);
    chk("t5_lanes", lo4, 128'd0);
    model_clear();
    #1; reset_L = 1'b1; or4 = 1;
    @(posedge clk_f); #1;
    for (int w = 0; w < 4; w++) push4(32'h60 + w);
    chk("t5_fresh", lo4, {32'h63, 32'h62, 32'h61, 32'h60});
    cyc();

`ifdef BYTE_STRIP_PARITY_EN
    v2 = 1; d2 = 32'h7; cyc();
    d2 = 32'h3; cyc(); v2 = 0;
    chk("t6_par", {126'd0, p2}, 128'h1);
    cyc();
`endif

    // Random traffic on both instances.
    for (int n = 0; n < 600; n++) begin
      v2 = ($urandom_range(0, 3) != 0); d2 = $urandom;
      f2 = ($urandom_range(0, 7) == 0); or2 = ($urandom_range(0, 3) != 0);
      v4 = ($urandom_range(0, 3) != 0); d4 = $urandom;
      f4 = ($urandom_range(0, 7) == 0); or4 = ($urandom_range(0, 2) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
